// File: rtl/rtsnoc_port_arbiter_if.sv
// Bus bundle for rtsnoc_port_arbiter.
// It groups three sets of signals:
//   - the TX requester side: req_valid_i, req_flit_i, req_ready_o, gnt_o
//   - the router local port: noc_din_o, noc_wr_o, noc_wait_i, noc_dout_i, noc_nd_i, noc_rd_o
//   - the RX consumer side: rx_flit_o, rx_valid_o, rx_ready_i, rx_count_o
// Modports:
//   - slave: the arbiter.
//   - master: whatever drives the requester, router and consumer sides.
interface rtsnoc_port_arbiter_if #(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned SOC_SIZE_X     = 1,
  parameter int unsigned SOC_SIZE_Y     = 1,
  parameter int unsigned NOC_DATA_WIDTH = 16,
  parameter int unsigned RX_DEPTH       = 4
);
  localparam int unsigned BUS   = NOC_DATA_WIDTH + 2*SOC_SIZE_X + 2*SOC_SIZE_Y + 6;
  localparam int unsigned GNT_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(RX_DEPTH) + 1;

  logic [N_REQ-1:0]     req_valid_i;
  logic [N_REQ*BUS-1:0] req_flit_i;
  logic [N_REQ-1:0]     req_ready_o;
  logic [GNT_W-1:0]     gnt_o;
  logic [BUS-1:0]       noc_din_o;
  logic                 noc_wr_o;
  logic                 noc_wait_i;
  logic [BUS-1:0]       noc_dout_i;
  logic                 noc_nd_i;
  logic                 noc_rd_o;
  logic [BUS-1:0]       rx_flit_o;
  logic                 rx_valid_o;
  logic                 rx_ready_i;
  logic [CNT_W-1:0]     rx_count_o;

  modport slave (
    input  req_valid_i, req_flit_i, noc_wait_i, noc_dout_i, noc_nd_i, rx_ready_i,
    output req_ready_o, gnt_o, noc_din_o, noc_wr_o, noc_rd_o, rx_flit_o, rx_valid_o, rx_count_o
  );

  modport master (
    output req_valid_i, req_flit_i, noc_wait_i, noc_dout_i, noc_nd_i, rx_ready_i,
    input  req_ready_o, gnt_o, noc_din_o, noc_wr_o, noc_rd_o, rx_flit_o, rx_valid_o, rx_count_o
  );
endinterface

// File: rtl/rtsnoc_port_arbiter.sv
// RTSNoC router local-port sharer.
//
// TX side: N_REQ requesters are round-robin arbitrated onto noc_din_o/noc_wr_o.
//   - One flit is issued per three cycles at most: grant, write strobe, gap.
// RX side: flits are popped from the router via noc_nd_i/noc_rd_o.
//   - They land in a RX_DEPTH-entry FIFO.
//   - The FIFO is drained through a valid/ready consumer port.
//
// Ports:
//   - clk_i, rst_i: clock and synchronous active-high reset.
//   - bus (slave modport of rtsnoc_port_arbiter_if): carries the requester, router and consumer signals.
//
// Optional feature, macro RTSNOC_ARB_ORIG_STAMP_EN:
//   - When defined, the origin fields of each granted flit are overwritten with NOC_X/NOC_Y/NOC_LOCAL_ADR.
//   - When undefined, flits are forwarded unmodified.
module rtsnoc_port_arbiter #(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned SOC_SIZE_X     = 1,
  parameter int unsigned SOC_SIZE_Y     = 1,
  parameter int unsigned NOC_DATA_WIDTH = 16,
  parameter int unsigned RX_DEPTH       = 4,
  parameter int unsigned NOC_LOCAL_ADR  = 0,
  parameter int unsigned NOC_X          = 0,
  parameter int unsigned NOC_Y          = 0
) (
  input logic                 clk_i,
  input logic                 rst_i,
  rtsnoc_port_arbiter_if.slave bus
);
  localparam int unsigned BUS    = NOC_DATA_WIDTH + 2*SOC_SIZE_X + 2*SOC_SIZE_Y + 6;
  localparam int unsigned GNT_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned PTR_W  = $clog2(RX_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned ORIG_W = SOC_SIZE_X + SOC_SIZE_Y + 3;

`ifdef RTSNOC_ARB_ORIG_STAMP_EN
  localparam bit STAMP_EN = 1'b1;
`else
  localparam bit STAMP_EN = 1'b0;
`endif

  localparam logic [ORIG_W-1:0] ORIG_STAMP =
    {SOC_SIZE_X'(NOC_X), SOC_SIZE_Y'(NOC_Y), 3'(NOC_LOCAL_ADR)};

  // ---------------------------------------------------------------- TX side
  typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_SEND = 2'd1, TX_GAP = 2'd2} tx_state_e;

  tx_state_e        tx_state_q, tx_state_d;
  logic [GNT_W-1:0] gnt_q;
  logic [GNT_W-1:0] win_c;
  logic [BUS-1:0]   din_q;
  logic [BUS-1:0]   sel_flit_c;
  logic             wr_q;
  logic             grant_c;
  logic [N_REQ-1:0] ready_c;
  int unsigned      scan_c;

  // TX state register
  always_ff @(posedge clk_i) begin
    if (rst_i) tx_state_q <= TX_IDLE;
    else       tx_state_q <= tx_state_d;
  end

  // TX next state
  always_comb begin
    tx_state_d = tx_state_q;
    case (tx_state_q)
      TX_IDLE: if (grant_c) tx_state_d = TX_SEND;
      TX_SEND: tx_state_d = TX_GAP;
      TX_GAP:  tx_state_d = TX_IDLE;
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // TX outputs: round-robin winner, selected flit, one-hot ready
  always_comb begin
    win_c      = gnt_q;
    scan_c     = 0;
    sel_flit_c = '0;
    ready_c    = '0;
    // Scan farthest offset first so the nearest valid index after gnt_q wins.
    for (int unsigned i = N_REQ; i >= 1; i--) begin
      scan_c = 32'(gnt_q) + i;
      if (scan_c >= N_REQ) scan_c = scan_c - N_REQ;
      if (bus.req_valid_i[scan_c[GNT_W-1:0]]) win_c = scan_c[GNT_W-1:0];
    end
    grant_c = (tx_state_q == TX_IDLE) && (|bus.req_valid_i) && !bus.noc_wait_i;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (win_c == GNT_W'(k)) sel_flit_c = bus.req_flit_i[k*BUS +: BUS];
    end
    if (STAMP_EN) sel_flit_c[BUS-1 -: ORIG_W] = ORIG_STAMP;
    if (grant_c) ready_c[win_c] = 1'b1;
  end

  // TX registered outputs; din holds until the next grant
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gnt_q <= GNT_W'(N_REQ - 1);
      din_q <= '0;
      wr_q  <= 1'b0;
    end else begin
      wr_q <= (tx_state_d == TX_SEND);
      if (grant_c) begin
        gnt_q <= win_c;
        din_q <= sel_flit_c;
      end
    end
  end

  // ---------------------------------------------------------------- RX side
  typedef enum logic [1:0] {RX_IDLE = 2'd0, RX_ACK = 2'd1, RX_GAP = 2'd2} rx_state_e;

  rx_state_e        rx_state_q, rx_state_d;
  logic [BUS-1:0]   mem [RX_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             rd_q;
  logic             push_c;
  logic             pop_c;

  // RX state register
  always_ff @(posedge clk_i) begin
    if (rst_i) rx_state_q <= RX_IDLE;
    else       rx_state_q <= rx_state_d;
  end

  // RX next state
  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      RX_IDLE: if (push_c) rx_state_d = RX_ACK;
      RX_ACK:  rx_state_d = RX_GAP;
      RX_GAP:  rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // RX outputs: push only with room, so the router keeps the flit while full
  always_comb begin
    push_c = (rx_state_q == RX_IDLE) && bus.noc_nd_i && (count_q < CNT_W'(RX_DEPTH));
    pop_c  = (count_q != '0) && bus.rx_ready_i;
  end

  // RX pointers, occupancy and read strobe
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rd_q     <= 1'b0;
    end else begin
      rd_q <= (rx_state_d == RX_ACK);
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  // FIFO storage; contents are don't-care once pointers reset
  always_ff @(posedge clk_i) begin
    if (push_c) mem[wr_ptr_q] <= bus.noc_dout_i;
  end

  assign bus.req_ready_o = ready_c;
  assign bus.gnt_o       = gnt_q;
  assign bus.noc_din_o   = din_q;
  assign bus.noc_wr_o    = wr_q;
  assign bus.noc_rd_o    = rd_q;
  assign bus.rx_flit_o   = mem[rd_ptr_q];
  assign bus.rx_valid_o  = (count_q != '0);
  assign bus.rx_count_o  = count_q;
endmodule

// File: tb/tb_rtsnoc_port_arbiter.sv
// Scoreboard bench for rtsnoc_port_arbiter (N_REQ=4, 26-bit flits, RX_DEPTH=4).
// Inputs change 2ns after the rising edge; outputs are sampled on the falling edge.
module tb_rtsnoc_port_arbiter;
  localparam int unsigned N_REQ = 4;
  localparam int unsigned SX    = 1;
  localparam int unsigned SY    = 1;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned BUS   = DW + 2*SX + 2*SY + 6;

  typedef struct packed {
    logic [1:0]     gnt;
    logic [BUS-1:0] flit;
  } tx_exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rtsnoc_port_arbiter_if #(.N_REQ(N_REQ), .SOC_SIZE_X(SX), .SOC_SIZE_Y(SY),
                           .NOC_DATA_WIDTH(DW), .RX_DEPTH(DEPTH)) bus ();

  rtsnoc_port_arbiter #(.N_REQ(N_REQ), .SOC_SIZE_X(SX), .SOC_SIZE_Y(SY),
                        .NOC_DATA_WIDTH(DW), .RX_DEPTH(DEPTH),
                        .NOC_LOCAL_ADR(5), .NOC_X(1), .NOC_Y(0))
    dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int unsigned    n_pass = 0;
  int unsigned    n_total = 0;
  int unsigned    rd_pulses = 0;
  tx_exp_t        tx_q[$];
  logic [BUS-1:0] rx_q[$];
  logic [BUS-1:0] rtr_q[$];
  logic [BUS-1:0] flits [N_REQ];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Expected flit as seen on noc_din_o: origin {X,Y,local} = {1,0,5} when stamping
  function automatic logic [BUS-1:0] exp_flit(input logic [BUS-1:0] f);
    logic [BUS-1:0] r;
    r = f;
`ifdef RTSNOC_ARB_ORIG_STAMP_EN
    r[BUS-1 -: 5] = 5'b1_0_101;
`endif
    return r;
  endfunction

  function automatic logic [BUS-1:0] rxf(input int unsigned i);
    return BUS'(32'h0150_0000 + i * 32'h111);
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic inject_rx(input logic [BUS-1:0] f);
    rtr_q.push_back(f);
    rx_q.push_back(f);
  endtask

  // One isolated grant starting from TX_IDLE; returns in TX_IDLE
  task automatic tx_one(input logic [3:0] v, input int unsigned w);
    tx_exp_t e;
    bus.req_valid_i = v;
    @(negedge clk);
    check("tx_one_ready", 32'(bus.req_ready_o), 32'(4'b0001 << w));
    e.gnt  = 2'(w);
    e.flit = exp_flit(flits[w]);
    tx_q.push_back(e);
    tick();
    bus.req_valid_i = '0;
    tick();
    tick();
  endtask

  // Router model: holds a flit with nd high until it sees the read strobe
  initial begin
    bus.noc_nd_i   = 1'b0;
    bus.noc_dout_i = '0;
    forever begin
      @(negedge clk);
      if (bus.noc_rd_o && rtr_q.size() != 0) void'(rtr_q.pop_front());
      bus.noc_nd_i   = (rtr_q.size() != 0);
      bus.noc_dout_i = (rtr_q.size() != 0) ? rtr_q[0] : '0;
    end
  end

  // Monitor: scores each router write and each consumer pop against the queues
  initial begin
    tx_exp_t        e;
    logic [BUS-1:0] r;
    forever begin
      @(negedge clk);
      if (bus.noc_wr_o) begin
        if (tx_q.size() == 0) begin
          n_total++;
          $display("FAIL tx_unexpected_wr: flit %0h with nothing expected at %0t", bus.noc_din_o, $time);
        end else begin
          e = tx_q.pop_front();
          check("tx_flit", 32'(bus.noc_din_o), 32'(e.flit));
          check("tx_gnt", 32'(bus.gnt_o), 32'(e.gnt));
        end
      end
      if (bus.rx_valid_o && bus.rx_ready_i) begin
        if (rx_q.size() == 0) begin
          n_total++;
          $display("FAIL rx_unexpected_pop: flit %0h with nothing expected at %0t", bus.rx_flit_o, $time);
        end else begin
          r = rx_q.pop_front();
          check("rx_flit", 32'(bus.rx_flit_o), 32'(r));
        end
      end
      if (bus.noc_rd_o) rd_pulses++;
    end
  end

  // Stimulus
  initial begin
    tx_exp_t     e;
    int unsigned base;

    flits[0] = 26'h3E0_1A00;
    flits[1] = 26'h0A1_B2C1;
    flits[2] = 26'h123_4562;
    flits[3] = 26'h2FE_DCB3;
    rst = 1'b1;
    bus.req_valid_i = '0;
    for (int unsigned k = 0; k < N_REQ; k++) bus.req_flit_i[k*BUS +: BUS] = flits[k];
    bus.noc_wait_i = 1'b0;
    bus.rx_ready_i = 1'b0;

    // Reset state
    tick();
    tick();
    @(negedge clk);
    check("rst_wr", 32'(bus.noc_wr_o), 32'd0);
    check("rst_rd", 32'(bus.noc_rd_o), 32'd0);
    check("rst_din", 32'(bus.noc_din_o), 32'd0);
    check("rst_gnt", 32'(bus.gnt_o), 32'd3);
    check("rst_count", 32'(bus.rx_count_o), 32'd0);
    check("rst_valid", 32'(bus.rx_valid_o), 32'd0);
    check("rst_ready", 32'(bus.req_ready_o), 32'd0);
    tick();
    rst = 1'b0;

    // All four requesters valid: grants 0,1,2,3,0 every third cycle
    bus.req_valid_i = 4'b1111;
    for (int unsigned i = 0; i < 5; i++) begin
      e.gnt  = 2'(i % 4);
      e.flit = exp_flit(flits[i % 4]);
      tx_q.push_back(e);
    end
    for (int unsigned c = 0; c < 15; c++) begin
      @(negedge clk);
      check("rr_ready", 32'(bus.req_ready_o),
            (c % 3 == 0) ? 32'(4'b0001 << ((c / 3) % 4)) : 32'd0);
      check("rr_wr", 32'(bus.noc_wr_o), (c % 3 == 1) ? 32'd1 : 32'd0);
      tick();
    end
    bus.req_valid_i = '0;

    // Router busy blocks requester 2 until wait drops
    bus.req_valid_i = 4'b0100;
    bus.noc_wait_i  = 1'b1;
    for (int unsigned c = 0; c < 5; c++) begin
      @(negedge clk);
      check("wait_ready", 32'(bus.req_ready_o), 32'd0);
      tick();
    end
    bus.noc_wait_i = 1'b0;
    @(negedge clk);
    check("wait_drop_ready", 32'(bus.req_ready_o), 32'b0100);
    e.gnt  = 2'd2;
    e.flit = exp_flit(flits[2]);
    tx_q.push_back(e);
    tick();
    bus.req_valid_i = '0;
    bus.noc_wait_i  = 1'b1;
    tick();
    tick();
    bus.noc_wait_i = 1'b0;

    // Pointer behaviour: 3, then only 1 -> 1, then {0,1} -> 0
    tx_one(4'b1000, 3);
    tx_one(4'b0010, 1);
    tx_one(4'b0011, 0);
    @(negedge clk);
    check("tx_drain_1", 32'(tx_q.size()), 32'd0);

    // RX backpressure: exactly four acks while the consumer stalls
    bus.rx_ready_i = 1'b0;
    base = rd_pulses;
    for (int unsigned i = 0; i < 6; i++) inject_rx(rxf(i));
    repeat (20) tick();
    @(negedge clk);
    check("rx_full_pulses", rd_pulses - base, 32'd4);
    check("rx_full_count", 32'(bus.rx_count_o), 32'd4);
    check("rx_full_head", 32'(bus.rx_flit_o), 32'(rxf(0)));
    check("rx_full_nd_held", 32'(bus.noc_nd_i), 32'd1);
    tick();
    bus.rx_ready_i = 1'b1;
    repeat (20) tick();
    @(negedge clk);
    check("rx_drain_pulses", rd_pulses - base, 32'd6);
    check("rx_drain_count", 32'(bus.rx_count_o), 32'd0);
    check("rx_drain_q", 32'(rx_q.size()), 32'd0);
    tick();
    bus.rx_ready_i = 1'b0;

    // Simultaneous push and pop at count 2
    inject_rx(rxf(10));
    inject_rx(rxf(11));
    repeat (10) tick();
    @(negedge clk);
    check("pp_pre_count", 32'(bus.rx_count_o), 32'd2);
    tick();
    inject_rx(rxf(12));
    bus.rx_ready_i = 1'b1;
    @(negedge clk);
    check("pp_nd_seen", 32'(bus.noc_nd_i), 32'd1);
    check("pp_head_a", 32'(bus.rx_flit_o), 32'(rxf(10)));
    tick();
    bus.rx_ready_i = 1'b0;
    @(negedge clk);
    check("pp_count", 32'(bus.rx_count_o), 32'd2);
    check("pp_head_b", 32'(bus.rx_flit_o), 32'(rxf(11)));
    repeat (4) tick();
    bus.rx_ready_i = 1'b1;
    repeat (4) tick();
    bus.rx_ready_i = 1'b0;
    @(negedge clk);
    check("pp_drain_count", 32'(bus.rx_count_o), 32'd0);

    // Reset during TX_SEND with one flit buffered
    inject_rx(rxf(20));
    repeat (6) tick();
    @(negedge clk);
    check("mid_rst_pre_count", 32'(bus.rx_count_o), 32'd1);
    bus.req_valid_i = 4'b0001;
    e.gnt  = 2'd0;
    e.flit = exp_flit(flits[0]);
    tx_q.push_back(e);
    tick();
    bus.req_valid_i = '0;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_send_wr", 32'(bus.noc_wr_o), 32'd1);
    tick();
    rst = 1'b0;
    rx_q.delete();
    @(negedge clk);
    check("mid_rst_wr", 32'(bus.noc_wr_o), 32'd0);
    check("mid_rst_count", 32'(bus.rx_count_o), 32'd0);
    check("mid_rst_valid", 32'(bus.rx_valid_o), 32'd0);
    check("mid_rst_gnt", 32'(bus.gnt_o), 32'd3);

    repeat (5) tick();
    @(negedge clk);
    check("tx_drain_final", 32'(tx_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
